pc_fetch_unit: RTL and testbench

//  Program-counter register and instruction-fetch sequencer. It sits directly downstream of the

---
 rtl/pc_fetch_unit_pkg.sv | 11 +
 rtl/pc_fetch_unit.sv | 58 +++++
 tb/tb_pc_fetch_unit.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// pc_fetch_unit_pkg: fetch FSM encoding and default parameters
package pc_fetch_unit_pkg;
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_VALID = 2'd1,
        S_HALT  = 2'd2
    } fetch_state_t;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_PC_STEP    = 1;
    localparam int DEF_RESET_PC   = 0;
endpackage

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register and ready/valid instruction-fetch sequencer
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int                    PC_STEP    = DEF_PC_STEP,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(DEF_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] next_pc,
    input  logic                  stall,
    input  logic                  halt,
    output logic [DATA_WIDTH-1:0] pc_seq,
    output logic [DATA_WIDTH-1:0] pc_cur,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_ready,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic [DATA_WIDTH-1:0] instr,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic                  halted,
    output logic [DATA_WIDTH-1:0] retire_cnt
);
    fetch_state_t state, state_nxt;
    logic fetch_done, accept;
    assign pc_seq      = pc_cur + DATA_WIDTH'(PC_STEP);
    assign imem_addr   = pc_cur;
    assign instr_valid = state == S_VALID;
    assign halted      = state == S_HALT;
    // the request flop gates completion so a ready seen while reset or idle is ignored
    assign fetch_done  = state == S_FETCH && imem_req && imem_ready;
    assign accept      = state == S_VALID && instr_ready && !stall;
    always_comb begin
        state_nxt = fetch_done ? S_VALID :
                    accept ? (halt ? S_HALT : S_FETCH) :
                    (state == S_HALT && !halt) ? S_FETCH : state;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_FETCH;
            imem_req   <= 1'b0;
            pc_cur     <= RESET_PC;
            instr      <= '0;
            retire_cnt <= '0;
        end else begin
            state    <= state_nxt;
            imem_req <= state_nxt == S_FETCH;
            if (fetch_done)
                instr <= imem_rdata;
            if (accept) begin
                pc_cur     <= next_pc;
                retire_cnt <= retire_cnt + DATA_WIDTH'(1);
            end
        end
    end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed scenarios plus randomized run against a transaction-level model
module tb_pc_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] next_pc, next_pc_r = '0;
    logic        follow = 1'b0;
    logic        stall = 1'b0, halt = 1'b0, imem_ready = 1'b0, instr_ready = 1'b0;
    logic [31:0] pc_seq, pc_cur, imem_addr, imem_rdata, instr, retire_cnt;
    logic        imem_req, instr_valid, halted;
    int          n_checks = 0, n_errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    assign imem_rdata = mem_word(imem_addr);
    assign next_pc    = follow ? pc_seq : next_pc_r;

    pc_fetch_unit dut (
        .clk(clk), .rst(rst), .next_pc(next_pc), .stall(stall), .halt(halt),
        .pc_seq(pc_seq), .pc_cur(pc_cur), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr(instr),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .halted(halted),
        .retire_cnt(retire_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_pc, exp_cnt;
        bit          have, parked;
        // reset asserted mid-cycle takes effect without a clock edge
        step();
        rst = 1'b1;
        #1;
        check("reset_req", 32'(imem_req), 0);
        check("reset_pc", pc_cur, 0);
        check("reset_cnt", retire_cnt, 0);
        check("reset_instr", instr, 0);
        check("reset_valid", 32'(instr_valid), 0);
        check("reset_halted", 32'(halted), 0);
        step();
        rst = 1'b0;
        imem_ready = 1'b1;
        instr_ready = 1'b1;
        follow = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            check("seq_req", 32'(imem_req), 1);
            check("seq_addr", imem_addr, 32'(i));
            step();
            check("seq_valid", 32'(instr_valid), 1);
            check("seq_instr", instr, mem_word(32'(i)));
            step();
        end
        check("seq_cnt", retire_cnt, 3);
        // branch target loaded on accept
        step();
        follow = 1'b0;
        next_pc_r = 32'h40;
        step();
        check("br_addr", imem_addr, 32'h40);
        check("br_req", 32'(imem_req), 1);
        check("br_seq", pc_seq, 32'h41);
        // stall holds the decoded word
        step();
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_instr", instr, mem_word(32'h40));
            check("stall_pc", pc_cur, 32'h40);
            check("stall_req", 32'(imem_req), 0);
        end
        stall = 1'b0;
        next_pc_r = 32'h44;
        step();
        check("unstall_pc", pc_cur, 32'h44);
        check("unstall_cnt", retire_cnt, 5);
        check("unstall_req", 32'(imem_req), 1);
        // halt at accept parks after loading next_pc
        step();
        halt = 1'b1;
        next_pc_r = 32'h10;
        step();
        check("halt_halted", 32'(halted), 1);
        check("halt_pc", pc_cur, 32'h10);
        check("halt_req", 32'(imem_req), 0);
        check("halt_cnt", retire_cnt, 6);
        step();
        check("halt_hold", 32'(halted), 1);
        halt = 1'b0;
        step();
        check("resume_req", 32'(imem_req), 1);
        check("resume_addr", imem_addr, 32'h10);
        check("resume_halted", 32'(halted), 0);
        // fetch waits on memory, then reset abandons it
        imem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("wait_req", 32'(imem_req), 1);
            check("wait_valid", 32'(instr_valid), 0);
        end
        rst = 1'b1;
        #1;
        check("abort_req", 32'(imem_req), 0);
        check("abort_pc", pc_cur, 0);
        check("abort_cnt", retire_cnt, 0);
        imem_ready = 1'b1;
        step();
        check("abort_late_ready", 32'(instr_valid), 0);
        rst = 1'b0;
        step();
        check("restart_req", 32'(imem_req), 1);
        check("restart_addr", imem_addr, 0);
        step();
        check("restart_instr", instr, mem_word(0));
        // PC wrap
        next_pc_r = 32'hFFFFFFFF;
        step();
        check("wrap_pc", pc_cur, 32'hFFFFFFFF);
        check("wrap_seq", pc_seq, 0);
        step();
        follow = 1'b1;
        step();
        check("wrap_addr", imem_addr, 0);
        check("wrap_req", 32'(imem_req), 1);
        // randomized run against a transaction-level model
        follow = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        imem_ready = 1'b0;
        instr_ready = 1'b0;
        step();
        exp_pc = 0;
        exp_cnt = 0;
        have = 0;
        parked = 0;
        for (int c = 0; c < 2000; c++) begin
            imem_ready  = ($urandom % 4) != 0;
            instr_ready = ($urandom % 3) != 0;
            stall       = ($urandom % 4) == 0;
            halt        = ($urandom % 5) == 0;
            next_pc_r   = ($urandom % 2) ? exp_pc + 32'd1 : $urandom;
            check("rnd_pc", pc_cur, exp_pc);
            check("rnd_seq", pc_seq, exp_pc + 32'd1);
            check("rnd_cnt", retire_cnt, exp_cnt);
            check("rnd_halted", 32'(halted), 32'(parked));
            check("rnd_valid", 32'(instr_valid), 32'(have));
            check("rnd_req", 32'(imem_req), 32'(!have && !parked));
            if (have)
                check("rnd_instr", instr, mem_word(exp_pc));
            if (imem_req)
                check("rnd_addr", imem_addr, exp_pc);
            if (parked) begin
                parked = halt;
            end else if (have) begin
                if (instr_ready && !stall) begin
                    exp_pc = next_pc_r;
                    exp_cnt = exp_cnt + 32'd1;
                    have = 0;
                    parked = halt;
                end
            end else if (imem_ready) begin
                have = 1;
            end
            step();
        end
        check("rnd_progress", 32'(exp_cnt > 100), 1);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
